// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared address-field layout, FSM state encoding and FUNCT3
//                width/sign constants for the data cache and data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Byte address layout: [tag | index | word | byte]
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int OFFSET_W   = 4;                  // byte offset inside a 16-byte block
  localparam int MEM_ADDR_W = ADDR_W - OFFSET_W;  // block address width

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_UPDATE    = 2'd3
  } cache_state_e;

  // RISC-V load/store width encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  // Unknown encodings fall back to a full-word access
  function automatic access_size_e access_size(input logic [2:0] f3);
    access_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      F3_W:        sz = SZ_WORD;
      default:     sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Merge store data into an existing word; half/word ignore the low offset bits
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] res;
    res = old_word;
    case (access_size(f3))
      SZ_BYTE: res[{off, 3'b000} +: 8]      = wdata[7:0];
      SZ_HALF: res[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: res                          = wdata;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
//  Module      : load_extract
//  Description : Selects a byte, half or word from a 32-bit word and applies
//                sign or zero extension according to FUNCT3.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extract
  import cache_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  assign byte_sel    = word_i[{byte_off_i, 3'b000} +: 8];
  assign half_sel    = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
  assign is_unsigned = funct3_i[2];

  // Width select plus extension; bit 2 of FUNCT3 marks the unsigned variants
  always_comb begin
    data_o = word_i;
    case (access_size(funct3_i))
      SZ_BYTE: data_o = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache
//  Description : Direct-mapped, write-back, write-allocate data cache with
//                zero-cycle hits and a 128-bit block interface to memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_cache
  import cache_pkg::*;
#(
  parameter int LINES       = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          READ,
  input  logic                          WRITE,
  input  logic [2:0]                    FUNCT3,
  input  logic [ADDR_W-1:0]             ADDRESS,
  input  logic [WORD_W-1:0]             WRITEDATA,
  output logic [WORD_W-1:0]             READDATA,
  output logic                          BUSYWAIT,
  output logic                          MEM_READ,
  output logic                          MEM_WRITE,
  output logic [MEM_ADDR_W-1:0]         MEM_ADDRESS,
  output logic [BLOCK_WORDS*WORD_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_WORDS*WORD_W-1:0] MEM_READDATA,
  input  logic                          MEM_BUSYWAIT
);

  localparam int BLOCK_W = BLOCK_WORDS * WORD_W;
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - OFFSET_W - IDX_W;

  // Line storage: control bits are reset, tag/data are not
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  cache_state_e          state_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [BLOCK_W-1:0]    mem_wdata_q;
  logic [BLOCK_W-1:0]    fill_q;
  logic [WORD_W-1:0]     readdata_q;

  // Address decode
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        word_sel;
  logic              req;
  logic              hit;
  logic              hit_idle;
  logic              read_hit;
  logic              write_hit;
  logic              victim_dirty;

  assign idx          = ADDRESS[OFFSET_W +: IDX_W];
  assign tag          = ADDRESS[ADDR_W-1 -: TAG_W];
  assign word_sel     = ADDRESS[3:2];
  assign req          = READ | WRITE;
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign hit_idle     = (state_q == S_IDLE) && hit;
  // WRITE has priority when both request lines are raised
  assign read_hit     = RESET && READ && !WRITE && hit_idle;
  assign write_hit    = RESET && WRITE && hit_idle;
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  // Word selected from the addressed line
  logic [BLOCK_W-1:0] line;
  logic [WORD_W-1:0]  line_word;
  logic [WORD_W-1:0]  load_word;

  assign line      = data_q[idx];
  assign line_word = line[{word_sel, 5'b00000} +: WORD_W];

  load_extract u_load_extract (
    .word_i     (line_word),
    .funct3_i   (FUNCT3),
    .byte_off_i (ADDRESS[1:0]),
    .data_o     (load_word)
  );

  // Store data merged into the addressed line
  logic [BLOCK_W-1:0] line_d;
  always_comb begin
    line_d = line;
    line_d[{word_sel, 5'b00000} +: WORD_W] = merge_store(line_word, WRITEDATA, FUNCT3, ADDRESS[1:0]);
  end

  // Stall whenever a request is pending that cannot complete as a hit this cycle
  assign BUSYWAIT      = RESET && req && !hit_idle;
  assign READDATA      = read_hit ? load_word : readdata_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

  // Hold the last delivered load value while no load is hitting
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      readdata_q <= '0;
    end else if (read_hit) begin
      readdata_q <= load_word;
    end
  end

  // Miss controller: writeback of a dirty victim, block fetch, line refill
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && !hit) begin
            if (victim_dirty) begin
              state_q     <= S_WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx};
              mem_wdata_q <= line;
            end else begin
              state_q    <= S_ALLOCATE;
              mem_read_q <= 1'b1;
              mem_addr_q <= ADDRESS[ADDR_W-1:OFFSET_W];
            end
          end
        end
        S_WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state_q     <= S_ALLOCATE;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= ADDRESS[ADDR_W-1:OFFSET_W];
          end
        end
        S_ALLOCATE: begin
          if (!MEM_BUSYWAIT) begin
            state_q    <= S_UPDATE;
            mem_read_q <= 1'b0;
            fill_q     <= MEM_READDATA;
          end
        end
        S_UPDATE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Valid/dirty bookkeeping: refill installs a clean line, a store hit dirties it
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == S_UPDATE) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays: refill from memory or merge a store hit
  always_ff @(posedge CLK) begin
    if (RESET && (state_q == S_UPDATE)) begin
      data_q[idx] <= fill_q;
      tag_q[idx]  <= tag;
    end else if (write_hit) begin
      data_q[idx] <= line_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_cache
//  Description : Self-checking bench for data_cache against a byte-level
//                architectural memory and a line-occupancy table.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         READ = 1'b0;
  logic         WRITE = 1'b0;
  logic [2:0]   FUNCT3 = 3'b000;
  logic [31:0]  ADDRESS = 32'd0;
  logic [31:0]  WRITEDATA = 32'd0;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int total = 0;
  int bad   = 0;

  // Main memory model: 64 blocks, fixed-latency busy period per transfer
  logic [127:0] mem_blk [64];
  int           lat = 3;
  int           cnt = 0;

  // Architectural view (what every load must return) and line occupancy
  logic [7:0]   arch [1024];
  bit           m_valid [8];
  bit           m_dirty [8];
  int           m_tag   [8];
  logic [31:0]  last_load = 32'd0;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } xfer_t;
  xfer_t xq[$];

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .FUNCT3        (FUNCT3),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  assign MEM_READDATA = mem_blk[MEM_ADDRESS[5:0]];
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt < lat);

  always @(posedge CLK) begin
    if ((MEM_READ | MEM_WRITE) && (cnt < lat)) cnt <= cnt + 1;
    else                                       cnt <= 0;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: protocol rules and record of completed transfers
  bit          p_rd = 0, p_wr = 0, p_done_rd = 0, p_done_wr = 0;
  logic [27:0] p_addr = 28'd0;
  always @(negedge CLK) begin
    bit done;
    check("mem_rw_exclusive", {127'd0, MEM_READ & MEM_WRITE}, 128'd0);
    if (((MEM_READ && p_rd) || (MEM_WRITE && p_wr)) && !(p_done_rd || p_done_wr))
      check("mem_addr_stable", {100'd0, MEM_ADDRESS}, {100'd0, p_addr});
    if (p_done_rd) check("mem_read_drop", {127'd0, MEM_READ}, 128'd0);
    if (p_done_wr) check("mem_write_drop", {127'd0, MEM_WRITE}, 128'd0);
    done = (MEM_READ | MEM_WRITE) && !MEM_BUSYWAIT;
    if (done) begin
      xq.push_back('{MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA});
      if (MEM_WRITE) mem_blk[MEM_ADDRESS[5:0]] = MEM_WRITEDATA;
    end
    p_rd      = MEM_READ;
    p_wr      = MEM_WRITE;
    p_addr    = MEM_ADDRESS;
    p_done_rd = done && MEM_READ;
    p_done_wr = done && MEM_WRITE;
  end

  function automatic int acc_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] arch_load(input logic [31:0] a, input logic [2:0] f3);
    int sz = acc_bytes(f3);
    int base = int'(a) & ~(sz - 1);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < sz; k++) v = v | (32'(arch[base + k]) << (8 * k));
    if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic arch_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    int sz = acc_bytes(f3);
    int base = int'(a) & ~(sz - 1);
    for (int k = 0; k < sz; k++) arch[base + k] = wd[8 * k +: 8];
  endtask

  function automatic logic [127:0] blk(input int b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8 * k +: 8] = arch[b * 16 + k];
    return r;
  endfunction

  task automatic sync_mem_from_arch();
    for (int b = 0; b < 64; b++) mem_blk[b] = blk(b);
  endtask

  task automatic sync_arch_from_mem();
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 16; k++) arch[b * 16 + k] = mem_blk[b][8 * k +: 8];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    sync_arch_from_mem();   // dirty lines are lost by reset
    last_load = 32'd0;
  endtask

  // One request, held until the cache stops stalling, checked against the model
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdata, output int stall);
    int    idx = (int'(a) >> 4) & 7;
    int    tg  = int'(a) >> 7;
    bit    req = rd | wr;
    bit    hit = m_valid[idx] && (m_tag[idx] == tg);
    int    exp_stall;
    xfer_t e[$];
    exp_stall = (!req || hit) ? 0 : (m_valid[idx] && m_dirty[idx]) ? 2 * lat + 4 : lat + 3;
    if (req && !hit) begin
      if (m_valid[idx] && m_dirty[idx])
        e.push_back('{1'b1, 28'(m_tag[idx] * 8 + idx), blk(m_tag[idx] * 8 + idx)});
      e.push_back('{1'b0, 28'(a >> 4), 128'd0});
    end
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITEDATA = wd;
    stall = 0;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT || stall > 500) break;
      stall++;
    end
    rdata = READDATA;
    check("stall_cycles", 128'(stall), 128'(exp_stall));
    if (rd && !wr) begin
      check("load_data", {96'd0, READDATA}, {96'd0, arch_load(a, f3)});
      last_load = arch_load(a, f3);
    end else if (!req) begin
      check("hold_data", {96'd0, READDATA}, {96'd0, last_load});
    end
    check("xfer_count", 128'(xq.size()), 128'(e.size()));
    foreach (e[i]) begin
      if (i < xq.size()) begin
        check("xfer_kind", {127'd0, xq[i].wr}, {127'd0, e[i].wr});
        check("xfer_addr", {100'd0, xq[i].addr}, {100'd0, e[i].addr});
        if (e[i].wr) check("xfer_wdata", xq[i].data, e[i].data);
      end
    end
    xq.delete();
    if (req && !hit) begin
      m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
    end
    if (wr) begin
      arch_store(a, f3, wd);
      m_dirty[idx] = 1;
    end
  endtask

  initial begin
    logic [31:0] rd_v;
    int          st;
    int          r;
    logic [2:0]  ld_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic [2:0]  st_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};

    for (int i = 0; i < 1024; i++) arch[i] = 8'($urandom);
    arch[32'h40] = 8'h78; arch[32'h41] = 8'h56; arch[32'h42] = 8'h34; arch[32'h43] = 8'h12;
    sync_mem_from_arch();
    model_reset();

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_readdata", {96'd0, READDATA}, 128'd0);
    check("rst_busywait", {127'd0, BUSYWAIT}, 128'd0);
    check("rst_mem_rw", {126'd0, MEM_READ, MEM_WRITE}, 128'd0);
    check("rst_mem_addr", {100'd0, MEM_ADDRESS}, 128'd0);
    check("rst_mem_wdata", MEM_WRITEDATA, 128'd0);
    @(posedge CLK); #1 RESET = 1'b1;

    // Cold miss, then a hit on the same word
    lat = 3;
    access(1, 0, 3'b010, 32'h40, 0, rd_v, st);
    check("t1_stall", 128'(st), 128'd6);
    check("t1_data", {96'd0, rd_v}, {96'd0, 32'h1234_5678});
    access(1, 0, 3'b010, 32'h40, 0, rd_v, st);
    check("t1_hit_stall", 128'(st), 128'd0);

    // Width and sign extension on word 0x000080FF
    access(0, 1, 3'b010, 32'h40, 32'h0000_80FF, rd_v, st);
    access(1, 0, 3'b000, 32'h40, 0, rd_v, st);
    check("lb", {96'd0, rd_v}, {96'd0, 32'hFFFF_FFFF});
    access(1, 0, 3'b100, 32'h40, 0, rd_v, st);
    check("lbu", {96'd0, rd_v}, {96'd0, 32'h0000_00FF});
    access(1, 0, 3'b001, 32'h42, 0, rd_v, st);
    check("lh_hi", {96'd0, rd_v}, {96'd0, 32'h0000_0000});
    access(1, 0, 3'b101, 32'h40, 0, rd_v, st);
    check("lhu", {96'd0, rd_v}, {96'd0, 32'h0000_80FF});

    // Byte store hit, then read-back
    access(0, 1, 3'b000, 32'h41, 32'h0000_00AB, rd_v, st);
    check("sb_stall", 128'(st), 128'd0);
    access(1, 0, 3'b010, 32'h40, 0, rd_v, st);
    check("sb_readback", {96'd0, rd_v}, {96'd0, 32'h0000_ABFF});

    // Dirty conflict (writeback then fetch), then clean conflict (fetch only)
    access(1, 0, 3'b010, 32'hC0, 0, rd_v, st);
    check("dirty_stall", 128'(st), 128'd10);
    access(1, 0, 3'b010, 32'h40, 0, rd_v, st);
    check("clean_stall", 128'(st), 128'd6);

    // Idle cycle keeps the last load value
    @(posedge CLK); #1 READ = 0; WRITE = 0;
    @(negedge CLK);
    check("idle_hold", {96'd0, READDATA}, {96'd0, rd_v});
    check("idle_busy", {127'd0, BUSYWAIT}, 128'd0);

    // Randomised mix of loads, stores, both, and no request
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      lat = $urandom_range(0, 4);
      a = ($urandom_range(0, 7) << 7) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      r = $urandom_range(0, 9);
      if (r <= 4)      access(1, 0, ld_f3[$urandom_range(0, 7)], a, 0, rd_v, st);
      else if (r <= 7) access(0, 1, st_f3[$urandom_range(0, 4)], a, $urandom, rd_v, st);
      else if (r == 8) access(1, 1, st_f3[$urandom_range(0, 4)], a, $urandom, rd_v, st);
      else             access(0, 0, 3'b010, a, 0, rd_v, st);
    end

    // Reset pulse, then reset in the middle of ALLOCATE
    @(posedge CLK); #1 READ = 0; WRITE = 0; RESET = 0;
    @(posedge CLK); #1 RESET = 1;
    model_reset();
    lat = 5;
    @(posedge CLK); #1 READ = 1; FUNCT3 = 3'b010; ADDRESS = 32'h40;
    repeat (3) @(negedge CLK);
    check("abort_mem_read", {127'd0, MEM_READ}, 128'd1);
    check("abort_mem_addr", {100'd0, MEM_ADDRESS}, 128'h4);
    @(posedge CLK); #1 RESET = 0; READ = 0;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_read_drop", {127'd0, MEM_READ}, 128'd0);
    check("abort_busy_drop", {127'd0, BUSYWAIT}, 128'd0);
    check("abort_no_xfer", 128'(xq.size()), 128'd0);
    xq.delete();
    @(posedge CLK); #1 RESET = 1;
    model_reset();
    access(1, 0, 3'b010, 32'h40, 0, rd_v, st);
    check("abort_remiss", 128'(st), 128'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and main data memory. It takes load/store requests with RISC-V width encoding (funct3) and returns load data with sign or zero extension. It stalls the pipeline through BUSYWAIT on a miss and exchanges whole 128-bit blocks with main memory using a read/write and busywait handshake.

## Interface
Parameters:
- LINES, 8, number of cache lines (power of two); index width log2(LINES)
- BLOCK_WORDS, 4, 32-bit words per block (fixed 4 in this revision; memory bus is 128 bits)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-low reset (asserted when 0, sampled on CLK posedge)
- READ  in  1  load request from the memory stage
- WRITE  in  1  store request from the memory stage
- FUNCT3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ADDRESS  in  32  byte address
- WRITEDATA  in  32  store data; byte and half use low bits
- READDATA  out  32  extended load data
- BUSYWAIT  out  1  stall request to the pipeline
- MEM_READ  out  1  block fetch request
- MEM_WRITE  out  1  block writeback request
- MEM_ADDRESS  out  28  block address (byte address >> 4)
- MEM_WRITEDATA  out  128  victim block; word 0 in [31:0]
- MEM_READDATA  in  128  fetched block
- MEM_BUSYWAIT  in  1  memory busy; a transfer completes in the first cycle it is 0 while the request is held

## Operation
- Address split: tag = ADDRESS[31:7], index = ADDRESS[6:4], word = ADDRESS[3:2], byte = ADDRESS[1:0]. The low bits are aligned down for H (bit 0 ignored) and W (bits 1:0 ignored).
- Per-line state: valid, dirty, 25-bit tag, 128-bit data.
- Hit: valid && tag match.
- FSM states:
  - IDLE
    - No request: stay.
    - Request with hit: stay.
    - Miss on a dirty line: go to WRITEBACK.
    - Miss on a clean or invalid line: go to ALLOCATE.
  - WRITEBACK
    - Drives MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=line data.
    - When MEM_BUSYWAIT=0: go to ALLOCATE.
  - ALLOCATE
    - Drives MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4].
    - When MEM_BUSYWAIT=0: go to UPDATE.
  - UPDATE
    - Writes MEM_READDATA into the line, sets tag, sets valid=1, clears dirty.
    - Goes to IDLE. The pending request is then re-evaluated as a hit.
- Read hit: selects the word, byte or half from the line. B/H are sign-extended; BU/HU are zero-extended.
- Write hit: merges the byte, half or word into the line and sets dirty=1.
- If READ and WRITE are both high, WRITE wins. If neither is high, BUSYWAIT=0 and READDATA holds the last value.
- FUNCT3 values outside the listed set are treated as W.

## Timing
- Reset values:
  - FSM = IDLE; all valid and dirty bits = 0.
  - READDATA = 0, BUSYWAIT = 0, MEM_READ = 0, MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0.
  - Data and tag arrays are not reset.
- Hit latency: 0 cycles.
  - READDATA is combinational from the arrays and valid in the request cycle; BUSYWAIT=0.
  - A write hit commits at the posedge ending that cycle.
- Miss: BUSYWAIT=1 combinationally in the first request cycle, held until the IDLE cycle after UPDATE, in which the hit completes.
- Clean-miss stall, with memory latency L (cycles of MEM_BUSYWAIT=1): 1 + L + 1 + 1 cycles minimum.
- Dirty miss: the WRITEBACK duration is added before ALLOCATE.
- Memory request rules:
  - MEM_READ and MEM_WRITE are never high together.
  - Each is held constant with stable MEM_ADDRESS until the completing cycle.
  - Each deasserts on the following posedge.
- Request inputs are held stable by the pipeline while BUSYWAIT=1. The cache does not re-latch them.
- Reset during WRITEBACK or ALLOCATE: the transfer is abandoned and MEM_* drops at that posedge. Lines already written are unaffected except that they are invalidated.
- Index wrap: addresses differing only in the tag conflict on the same line. No other aliasing.

## Structure
- Shared package cache_pkg:
  - Address field widths and positions.
  - FSM state enum (IDLE, WRITEBACK, ALLOCATE, UPDATE).
  - FUNCT3 width/sign constants, shared with data memory.
- One sub-module: load_extract. It is combinational and selects/extends byte, half or word from a 32-bit word using FUNCT3 and ADDRESS[1:0]. It is reusable by the uncached memory path.
- Arrays are plain registers inside data_cache.

## Test plan
- Reset, then LW 0x0000_0040 with memory returning word 0x1234_5678 at L=3:
  - BUSYWAIT high for 6 cycles.
  - MEM_READ with MEM_ADDRESS=0x0000004.
  - READDATA=0x1234_5678.
  - A repeat LW hits with BUSYWAIT=0.
- Word 0x0000_80FF at 0x40:
  - LB 0x40 gives 0xFFFF_FFFF.
  - LBU gives 0x0000_00FF.
  - LH 0x42 gives 0x0000_0000.
  - LHU 0x40 gives 0x0000_80FF.
- SB 0xAB to 0x41 on a hit:
  - No stall.
  - LW 0x40 gives 0x0000_ABFF.
  - The line is dirty.
- Conflict after the store above: LW 0x0000_00C0 (same index 4).
  - MEM_WRITE with MEM_ADDRESS=0x0000004 and the merged block.
  - Then MEM_READ with MEM_ADDRESS=0x000000C.
  - Never both high.
- Clean conflict miss: no MEM_WRITE pulse, only MEM_READ.
- RESET low during ALLOCATE:
  - MEM_READ=0 and BUSYWAIT=0 the next cycle.
  - A subsequent LW 0x40 misses again (line invalidated).
